uart_rx_sequencer: RTL

//  Receive-side controller for the UART. It owns the half-bit baud timer (hz_for_rx):
//  it holds the timer in reset while idle, starts it on a start-bit edge, and uses

---
 rtl/uart_rx_sequencer_if.sv | 12 +
 rtl/uart_rx_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_sequencer_if.sv
// Receive-data handshake between the UART receive sequencer and its consumer.
// The master side presents RxData/RxValid; the slave side returns RxReady.
interface uart_rx_sequencer_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] RxData;
   logic                 RxValid;
   logic                 RxReady;

   modport master (output RxData, output RxValid, input RxReady);
   modport slave  (input RxData, input RxValid, output RxReady);
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer. It owns the half-bit baud timer, samples at mid-bit and
// assembles frames LSB-first. Define UART_RX_PARITY_EN to add a parity bit after the data bits.
//
// state  | meaning
// IDLE   | timer held in reset, waiting for a falling edge on the line
// START  | timer running, first tick checks the start bit is still low
// DATA   | sample one data bit every second tick, LSB first
// PARITY | sample the parity bit (only with UART_RX_PARITY_EN)
// STOP   | sample the stop bit, then load, flag overrun or flag frame error
module uart_rx_sequencer #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PARITY_ODD  = 0
) (
   input  logic                       SystemClock,
   input  logic                       Reset,
   input  logic                       RxLine,
   input  logic                       NextBit,
   output logic                       TimerRun,
   uart_rx_sequencer_if.master        rxBus,
   output logic                       FrameError,
   output logic                       Overrun,
   output logic                       Busy
);

   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxState_t;

   rxState_t             state, stateNext;
   logic [IDX_W-1:0]     bitIdx, bitIdxNext;
   logic                 phase, phaseNext;
   logic [DATA_BITS-1:0] shiftReg, shiftNext;
   logic [SYNC_STAGES:0] syncReg;
   logic                 nextBitQ;
   logic [DATA_BITS-1:0] rxDataReg;
   logic                 rxValidReg;
   logic                 frameErrorReg, overrunReg;
   logic                 loadFrame, frameErrorNext, overrunNext;
   logic                 lineS, linePrev, fallEdge, tick;
   logic                 parityBad;

   // The oldest stage is edge history only; the stages below it form the synchronizer.
   assign lineS    = syncReg[SYNC_STAGES-1];
   assign linePrev = syncReg[SYNC_STAGES];
   assign fallEdge = linePrev & ~lineS;
   assign tick     = (NextBit != nextBitQ);

   assign TimerRun      = (state != IDLE);
   assign Busy          = (state != IDLE);
   assign rxBus.RxData  = rxDataReg;
   assign rxBus.RxValid = rxValidReg;
   assign FrameError    = frameErrorReg;
   assign Overrun       = overrunReg;

`ifdef UART_RX_PARITY_EN
   logic parityBadNext;

   always_ff @(posedge SystemClock or negedge Reset) begin
      if (!Reset) parityBad <= 1'b0;
      else        parityBad <= parityBadNext;
   end
`else
   assign parityBad = 1'b0 & PARITY_ODD[0];
`endif

   always_comb begin
      stateNext      = state;
      bitIdxNext     = bitIdx;
      phaseNext      = phase;
      shiftNext      = shiftReg;
      loadFrame      = 1'b0;
      frameErrorNext = 1'b0;
      overrunNext    = 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBadNext  = parityBad;
`endif
      case (state)
         IDLE: if (fallEdge) stateNext = START;
         START: if (tick) begin
            if (!lineS) begin
               stateNext  = DATA;
               bitIdxNext = '0;
               phaseNext  = 1'b0;
            end else begin
               stateNext = IDLE;
            end
         end
         DATA: if (tick) begin
            phaseNext = ~phase;
            if (phase) begin
               shiftNext = {lineS, shiftReg[DATA_BITS-1:1]};
               if (bitIdx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  stateNext = PARITY;
`else
                  stateNext = STOP;
`endif
               end else begin
                  bitIdxNext = bitIdx + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (tick) begin
            phaseNext = ~phase;
            if (phase) begin
               parityBadNext = ((^shiftReg) ^ lineS) != PARITY_ODD[0];
               stateNext     = STOP;
            end
         end
`endif
         STOP: if (tick) begin
            phaseNext = ~phase;
            if (phase) begin
               stateNext = IDLE;
               if (!lineS || parityBad) frameErrorNext = 1'b1;
               else if (rxValidReg)     overrunNext    = 1'b1;
               else                     loadFrame      = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge SystemClock or negedge Reset) begin
      if (!Reset) begin
         state         <= IDLE;
         bitIdx        <= '0;
         phase         <= 1'b0;
         shiftReg      <= '0;
         syncReg       <= '1;
         nextBitQ      <= 1'b0;
         rxDataReg     <= '0;
         rxValidReg    <= 1'b0;
         frameErrorReg <= 1'b0;
         overrunReg    <= 1'b0;
      end else begin
         state         <= stateNext;
         bitIdx        <= bitIdxNext;
         phase         <= phaseNext;
         shiftReg      <= shiftNext;
         syncReg       <= {syncReg[SYNC_STAGES-1:0], RxLine};
         nextBitQ      <= TimerRun ? NextBit : 1'b0;
         frameErrorReg <= frameErrorNext;
         overrunReg    <= overrunNext;
         // A new load takes priority over a same-cycle accept.
         if (loadFrame) begin
            rxDataReg  <= shiftReg;
            rxValidReg <= 1'b1;
         end else if (rxValidReg && rxBus.RxReady) begin
            rxValidReg <= 1'b0;
         end
      end
   end

endmodule
